mem_port_arbiter: RTL and testbench

Sequencer that shares the single physical memory port between the instruction-cache miss path and the data-cache miss/writeback path feeding the MEM stage. It accepts line-sized read requests from the I side and read or write requests from the D side, grants one at a time, and drives the physical port from registered copies of the granted request. It resolves conflicts round-robin and returns the completion pulse to the owning requester only.

---
 rtl/arb_types.sv | 30 +++
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_types.sv
// Shared types and constants for the I/D memory port arbiter.
package arb_types;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned OFFSET_W = 5;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_I_BUSY,
        ARB_D_BUSY
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Request as latched on a grant edge; drives the physical port.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [LINE_W-1:0] wdata;
    } mem_req_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between the I-cache miss path and the
// D-cache miss/writeback path, round-robin on conflicts.
module mem_port_arbiter
    import arb_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state;
    arb_state_t state_nxt;
    grant_t     last_grant;
    mem_req_t   req_q;
    mem_req_t   req_nxt;
    logic       d_pend;

    // A simultaneous read+write from D is serviced as a write.
    assign d_pend = d_read | d_write;

    // State, round-robin flag and the latched request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_grant <= GRANT_I;
            req_q      <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && state_nxt != ARB_IDLE) begin
                req_q      <= req_nxt;
                last_grant <= (state_nxt == ARB_D_BUSY) ? GRANT_D : GRANT_I;
            end
        end
    end

    // Grant selection in IDLE; completion on pmem_resp while busy.
    always_comb begin
        state_nxt     = state;
        req_nxt.addr  = line_align(i_addr);
        req_nxt.write = 1'b0;
        req_nxt.wdata = d_wdata;
        case (state)
            ARB_IDLE: begin
                if (d_pend && (!i_read || last_grant == GRANT_I)) begin
                    state_nxt     = ARB_D_BUSY;
                    req_nxt.addr  = line_align(d_addr);
                    req_nxt.write = d_write;
                end else if (i_read) begin
                    state_nxt = ARB_I_BUSY;
                end
            end
            ARB_I_BUSY, ARB_D_BUSY: begin
                if (pmem_resp) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Port strobes decode from state; completion routed to the owner only.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        pmem_address = req_q.addr;
        pmem_wdata   = req_q.wdata;
        i_rdata      = pmem_rdata;
        d_rdata      = pmem_rdata;
        case (state)
            ARB_I_BUSY: begin
                pmem_read = 1'b1;
                i_resp    = pmem_resp;
            end
            ARB_D_BUSY: begin
                pmem_read  = ~req_q.write;
                pmem_write = req_q.write;
                d_resp     = pmem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;
    import arb_types::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_read = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    logic mem_resp_auto = 1'b0;
    logic poke          = 1'b0;
    int   mem_lat       = 4;
    int   mem_cnt       = 0;

    int total = 0;
    int bad   = 0;

    // Requester bookkeeping
    int   n_i = 0;
    int   n_d = 0;
    int   n_strobe = 0;
    int   n_ord = 0;
    int   ord [8];
    logic drop_i = 1'b0;
    logic drop_d = 1'b0;

    // Reference model: who owns the port and what it was asked to do.
    int                m_owner  = 0;     // 0 none, 1 I, 2 D
    logic              m_last_d = 1'b0;  // D won the most recent grant
    logic [ADDR_W-1:0] m_addr   = '0;
    logic              m_wr     = 1'b0;
    logic [LINE_W-1:0] m_wdata  = '0;

    mem_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_addr       (i_addr),
        .i_resp       (i_resp),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_resp       (d_resp),
        .d_rdata      (d_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    assign pmem_resp  = mem_resp_auto | poke;
    assign pmem_rdata = {(LINE_W/ADDR_W){pmem_address}};

    // Memory: answers after mem_lat strobe cycles.
    always @(posedge clk) begin
        #1;
        mem_resp_auto = 1'b0;
        if (rst || !(pmem_read || pmem_write)) begin
            mem_cnt = 0;
        end else begin
            mem_cnt = mem_cnt + 1;
            if (mem_cnt == mem_lat) mem_resp_auto = 1'b1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner  = 0;
            m_last_d = 1'b0;
            m_addr   = '0;
            m_wr     = 1'b0;
            m_wdata  = '0;
        end else if (m_owner == 0) begin
            if ((d_read || d_write) && (!i_read || !m_last_d)) begin
                m_owner  = 2;
                m_last_d = 1'b1;
                m_addr   = (d_addr / 32) * 32;
                m_wr     = d_write;
                m_wdata  = d_wdata;
            end else if (i_read) begin
                m_owner  = 1;
                m_last_d = 1'b0;
                m_addr   = (i_addr / 32) * 32;
                m_wr     = 1'b0;
                m_wdata  = d_wdata;
            end
        end else if (pmem_resp) begin
            m_owner = 0;
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk1("pmem_read",  pmem_read,  m_owner == 1 || (m_owner == 2 && !m_wr));
        chk1("pmem_write", pmem_write, m_owner == 2 && m_wr);
        chkw("pmem_address", LINE_W'(pmem_address), LINE_W'(m_addr));
        chkw("pmem_wdata", pmem_wdata, m_wdata);
        chk1("i_resp", i_resp, m_owner == 1 && pmem_resp);
        chk1("d_resp", d_resp, m_owner == 2 && pmem_resp);
        if (i_resp) chkw("i_rdata", i_rdata, {(LINE_W/ADDR_W){m_addr}});
        if (d_resp) chkw("d_rdata", d_rdata, {(LINE_W/ADDR_W){m_addr}});
    end

    // One cycle of requester behaviour: drop a request in the cycle after its resp.
    task automatic tick();
        @(posedge clk);
        #2;
        if (drop_i) begin i_read = 1'b0; drop_i = 1'b0; end
        if (drop_d) begin d_read = 1'b0; d_write = 1'b0; drop_d = 1'b0; end
        if (pmem_read || pmem_write) n_strobe++;
        if (i_resp) begin
            n_i++; drop_i = 1'b1;
            if (n_ord < 8) ord[n_ord] = 1;
            n_ord++;
        end
        if (d_resp) begin
            n_d++; drop_d = 1'b1;
            if (n_ord < 8) ord[n_ord] = 2;
            n_ord++;
        end
    endtask

    task automatic run_until(input int target, input int budget);
        int k = 0;
        while ((n_i + n_d < target || i_read || d_read || d_write) && k < budget) begin
            tick();
            k++;
        end
        total++;
        if (k >= budget) begin
            bad++;
            $display("FAIL timeout: got %0d responses expected %0d", n_i + n_d, target);
        end
    endtask

    task automatic clear_counts();
        n_i = 0; n_d = 0; n_strobe = 0; n_ord = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        drop_i = 1'b0; drop_d = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk1("rst pmem_read", pmem_read, 1'b0);
        chk1("rst pmem_write", pmem_write, 1'b0);
        chkw("rst pmem_address", LINE_W'(pmem_address), '0);
        chkw("rst pmem_wdata", pmem_wdata, '0);
        chk1("rst i_resp", i_resp, 1'b0);
        chk1("rst d_resp", d_resp, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // I read, memory latency 4 strobe cycles
        clear_counts();
        mem_lat = 4;
        i_addr = 32'h0000_1234;
        i_read = 1'b1;
        chk1("t1 no strobe before grant", pmem_read, 1'b0);
        tick();
        chk1("t1 pmem_read", pmem_read, 1'b1);
        chkw("t1 address", LINE_W'(pmem_address), LINE_W'(32'h0000_1220));
        run_until(1, 40);
        chki("t1 strobe cycles", n_strobe, 4);
        chki("t1 i_resp count", n_i, 1);
        chki("t1 d_resp count", n_d, 0);

        // D write; d_wdata changes mid-transaction
        clear_counts();
        mem_lat = 3;
        d_addr = 32'h8000_0040;
        d_wdata = {32{8'hA5}};
        d_write = 1'b1;
        tick();
        chk1("t2 pmem_write", pmem_write, 1'b1);
        chk1("t2 pmem_read", pmem_read, 1'b0);
        chkw("t2 address", LINE_W'(pmem_address), LINE_W'(32'h8000_0040));
        d_wdata = '0;
        tick();
        chkw("t2 wdata held", pmem_wdata, {32{8'hA5}});
        run_until(1, 40);
        chki("t2 d_resp count", n_d, 1);
        chki("t2 i_resp count", n_i, 0);

        // Conflicts from reset: D, I, D, I
        do_reset();
        clear_counts();
        mem_lat = 2;
        i_addr = 32'h0000_0100; i_read = 1'b1;
        d_addr = 32'h0000_0200; d_read = 1'b1;
        run_until(2, 40);
        i_addr = 32'h0000_0300; i_read = 1'b1;
        d_addr = 32'h0000_0400; d_write = 1'b1;
        run_until(4, 40);
        chki("t3 grant 0", ord[0], 2);
        chki("t3 grant 1", ord[1], 1);
        chki("t3 grant 2", ord[2], 2);
        chki("t3 grant 3", ord[3], 1);

        // pmem_resp while idle
        clear_counts();
        poke = 1'b1;
        #1;
        chk1("t4 i_resp idle", i_resp, 1'b0);
        chk1("t4 d_resp idle", d_resp, 1'b0);
        tick();
        poke = 1'b0;
        chk1("t4 stays idle", pmem_read | pmem_write, 1'b0);
        chki("t4 resp count", n_i + n_d, 0);

        // Reset two cycles into a D read
        clear_counts();
        mem_lat = 1000;
        d_addr = 32'h3000_0000;
        d_read = 1'b1;
        tick();
        chk1("t5 pmem_read granted", pmem_read, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        chk1("t5 strobe drops async", pmem_read, 1'b0);
        chkw("t5 address cleared", LINE_W'(pmem_address), '0);
        d_read = 1'b0;
        tick();
        rst = 1'b0;
        poke = 1'b1;
        #1;
        chk1("t5 no d_resp after reset", d_resp, 1'b0);
        tick();
        poke = 1'b0;
        mem_lat = 2;
        i_addr = 32'h0000_5678;
        i_read = 1'b1;
        tick();
        chk1("t5 I granted", pmem_read, 1'b1);
        chkw("t5 I address", LINE_W'(pmem_address), LINE_W'(32'h0000_5660));
        run_until(1, 40);
        chki("t5 i_resp count", n_i, 1);
        chki("t5 d_resp count", n_d, 0);

        // Illegal read+write treated as write
        clear_counts();
        d_addr = 32'h0000_ABCD;
        d_wdata = {8{32'h1357_9BDF}};
        d_read = 1'b1;
        d_write = 1'b1;
        tick();
        chk1("t6 pmem_write", pmem_write, 1'b1);
        chk1("t6 pmem_read", pmem_read, 1'b0);
        chkw("t6 address", LINE_W'(pmem_address), LINE_W'(32'h0000_ABC0));
        run_until(1, 40);
        chki("t6 d_resp count", n_d, 1);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
